// File: rtl/ram_req_bridge_if.sv
// Request/response channel bundle between the core LSU/fetch port and ram_req_bridge.
// master = core side, slave = bridge side.
interface ram_req_bridge_if #(
  parameter int ID_W = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [63:0]     req_addr;
  logic            req_wen;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [63:0]     req_wdata;
  logic [ID_W-1:0] req_id;

  logic            resp_valid;
  logic            resp_ready;
  logic [63:0]     resp_rdata;
  logic            resp_err;
  logic            resp_wen;
  logic [ID_W-1:0] resp_id;

  modport master (
    output req_valid, req_addr, req_wen, req_size, req_signed, req_wdata, req_id,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err, resp_wen, resp_id,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_signed, req_wdata, req_id,
    output req_ready,
    output resp_valid, resp_rdata, resp_err, resp_wen, resp_id,
    input  resp_ready
  );
endinterface

// File: rtl/ram_req_bridge.sv
// Sized load/store bridge onto the 64-bit simulation RAM port with a response FIFO.
// Optional macro RAM_BRIDGE_PERF_EN adds read/write/stall performance counters.
//
// state   | meaning
// EMPTY   | no buffered responses, resp_valid low
// PARTIAL | some responses buffered, requests still accepted
// FULL    | RESP_DEPTH responses buffered, req_ready low
module ram_req_bridge #(
  parameter int RESP_DEPTH = 2,
  parameter int ID_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  ram_req_bridge_if.slave bus,
  output logic        ram_en,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  output logic [7:0]  ram_wmask,
  output logic        ram_wen,
  input  logic [63:0] ram_rdata
`ifdef RAM_BRIDGE_PERF_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [63:0]     rdata_mem [RESP_DEPTH];
  logic            err_mem   [RESP_DEPTH];
  logic            wen_mem   [RESP_DEPTH];
  logic [ID_W-1:0] id_mem    [RESP_DEPTH];

  logic        req_fire, aligned_fire, pop, misaligned;
  logic [7:0]  lane_mask;
  logic [2:0]  byte_off;
  logic [5:0]  shift_bits;
  logic [63:0] rd_shift, load_data, push_data;

  assign bus.req_ready = !reset && (state != FULL);
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign aligned_fire  = req_fire && !misaligned;
  assign byte_off      = bus.req_addr[2:0];
  assign shift_bits    = {byte_off, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    lane_mask  = 8'h01;
    unique case (bus.req_size)
      2'd0: begin misaligned = 1'b0;               lane_mask = 8'h01; end
      2'd1: begin misaligned = bus.req_addr[0];    lane_mask = 8'h03; end
      2'd2: begin misaligned = |bus.req_addr[1:0]; lane_mask = 8'h0F; end
      default: begin misaligned = |bus.req_addr[2:0]; lane_mask = 8'hFF; end
    endcase
  end

  // Reset blocks req_fire through req_ready, so the RAM port is idle in reset.
  assign ram_en    = aligned_fire;
  assign ram_wen   = aligned_fire && bus.req_wen;
  assign ram_addr  = aligned_fire ? {bus.req_addr[63:3], 3'b000} : 64'h0;
  assign ram_wmask = ram_wen ? (lane_mask << byte_off) : 8'h00;
  assign ram_wdata = aligned_fire ? (bus.req_wdata << shift_bits) : 64'h0;

  assign rd_shift = ram_rdata >> shift_bits;

  always_comb begin
    load_data = 64'h0;
    unique case (bus.req_size)
      2'd0: load_data = bus.req_signed ? {{56{rd_shift[7]}},  rd_shift[7:0]}  : {56'h0, rd_shift[7:0]};
      2'd1: load_data = bus.req_signed ? {{48{rd_shift[15]}}, rd_shift[15:0]} : {48'h0, rd_shift[15:0]};
      2'd2: load_data = bus.req_signed ? {{32{rd_shift[31]}}, rd_shift[31:0]} : {32'h0, rd_shift[31:0]};
      default: load_data = rd_shift;
    endcase
  end

  assign push_data = (misaligned || bus.req_wen) ? 64'h0 : load_data;
  assign pop       = bus.resp_valid && bus.resp_ready;

  always_comb begin
    count_nxt = count;
    state_nxt = state;
    unique case ({req_fire, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    if (count_nxt == '0)
      state_nxt = EMPTY;
    else if (count_nxt == DEPTH_C)
      state_nxt = FULL;
    else
      state_nxt = PARTIAL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        rdata_mem[i] <= 64'h0;
        err_mem[i]   <= 1'b0;
        wen_mem[i]   <= 1'b0;
        id_mem[i]    <= '0;
      end
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (req_fire) begin
        rdata_mem[wr_ptr] <= push_data;
        err_mem[wr_ptr]   <= misaligned;
        wen_mem[wr_ptr]   <= bus.req_wen;
        id_mem[wr_ptr]    <= bus.req_id;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign bus.resp_valid = !reset && (state != EMPTY);
  assign bus.resp_rdata = bus.resp_valid ? rdata_mem[rd_ptr] : 64'h0;
  assign bus.resp_err   = bus.resp_valid && err_mem[rd_ptr];
  assign bus.resp_wen   = bus.resp_valid && wen_mem[rd_ptr];
  assign bus.resp_id    = bus.resp_valid ? id_mem[rd_ptr] : '0;

`ifdef RAM_BRIDGE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_rd_cnt    <= 32'h0;
      perf_wr_cnt    <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (aligned_fire && !bus.req_wen)
        perf_rd_cnt <= perf_rd_cnt + 32'd1;
      if (aligned_fire && bus.req_wen)
        perf_wr_cnt <= perf_wr_cnt + 32'd1;
      if (bus.req_valid && !bus.req_ready)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ram_req_bridge.sv
// Directed scoreboard bench for ram_req_bridge: expected responses are queued at
// request acceptance and checked by an independent monitor.
module tb_ram_req_bridge;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_req_bridge_if #(.ID_W(4)) bus ();

  logic        ram_en, ram_wen;
  logic [63:0] ram_addr, ram_wdata, ram_rdata;
  logic [7:0]  ram_wmask;
`ifdef RAM_BRIDGE_PERF_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  ram_req_bridge #(.RESP_DEPTH(2), .ID_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask),
    .ram_wen   (ram_wen),
    .ram_rdata (ram_rdata)
`ifdef RAM_BRIDGE_PERF_EN
    ,
    .perf_rd_cnt    (perf_rd_cnt),
    .perf_wr_cnt    (perf_wr_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  logic [63:0] ram [16];
  assign ram_rdata = ram_en ? ram[ram_addr[6:3]] : 64'h0;
  always @(posedge clk)
    if (ram_en && ram_wen)
      for (int b = 0; b < 8; b++)
        if (ram_wmask[b]) ram[ram_addr[6:3]][8*b +: 8] <= ram_wdata[8*b +: 8];

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic        wen;
    logic [3:0]  id;
  } resp_t;

  resp_t sb[$];
  resp_t mon_e;
  int vecs = 0;
  int miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          vecs++;
          miss++;
          $display("FAIL unexpected_resp: got id %0d expected no response", bus.resp_id);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
          chk("resp_err",   64'(bus.resp_err), 64'(mon_e.err));
          chk("resp_wen",   64'(bus.resp_wen), 64'(mon_e.wen));
          chk("resp_id",    64'(bus.resp_id),  64'(mon_e.id));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
  endtask

  // Called at posedge+1; returns at the negedge of the accepting cycle.
  task automatic issue(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                       input logic sgn, input logic [63:0] wdata, input logic [3:0] id,
                       input logic [63:0] exp_rdata, input logic exp_err);
    int n = 0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_wen    = wen;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_wdata  = wdata;
    bus.req_id     = id;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      vecs++;
      miss++;
      $display("FAIL req_accept_timeout id %0d: got ready %b expected 1", id, bus.req_ready);
    end else begin
      sb.push_back(resp_t'{exp_rdata, exp_err, wen, id});
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 0; bus.req_addr = 0; bus.req_wen = 0; bus.req_size = 0;
    bus.req_signed = 0; bus.req_wdata = 0; bus.req_id = 0; bus.resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) ram[i] = 64'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 0);
    chk("rst_ram_en", 64'(ram_en), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(bus.req_ready), 1);
    chk("post_rst_resp_valid", 64'(bus.resp_valid), 0);
    chk("post_rst_resp_rdata", bus.resp_rdata, 0);
    step();

    issue(64'h8000_0000, 1, 3, 0, 64'h1122_3344_5566_7788, 4'd1, 64'h0, 0);
    chk("st_d_wmask", 64'(ram_wmask), 64'hFF);
    chk("st_d_wen", 64'(ram_wen), 1);
    chk("st_d_addr", ram_addr, 64'h8000_0000);
    chk("st_d_wdata", ram_wdata, 64'h1122_3344_5566_7788);
    step();
    issue(64'h8000_0005, 1, 0, 0, 64'hAB, 4'd2, 64'h0, 0);
    chk("st_b_addr", ram_addr, 64'h8000_0000);
    chk("st_b_wmask", 64'(ram_wmask), 64'h20);
    chk("st_b_lane", 64'(ram_wdata[47:40]), 64'hAB);
    step();
    issue(64'h8000_0000, 0, 3, 0, 64'h0, 4'd3, 64'h1122_AB44_5566_7788, 0);
    chk("ld_d_en", 64'(ram_en), 1);
    chk("ld_d_wen", 64'(ram_wen), 0);
    chk("ld_d_wmask", 64'(ram_wmask), 0);
    step();
    issue(64'h8000_0000, 1, 3, 0, 64'h8001_0000_0000_0000, 4'd4, 64'h0, 0); step();
    issue(64'h8000_0006, 0, 1, 1, 64'h0, 4'd5, 64'hFFFF_FFFF_FFFF_8001, 0); step();
    issue(64'h8000_0006, 0, 1, 0, 64'h0, 4'd6, 64'h0000_0000_0000_8001, 0); step();
    issue(64'h8000_0007, 0, 0, 1, 64'h0, 4'd7, 64'hFFFF_FFFF_FFFF_FF80, 0); step();
    issue(64'h8000_0004, 0, 2, 0, 64'h0, 4'd8, 64'h0000_0000_8001_0000, 0); step();
    issue(64'h8000_0002, 0, 2, 0, 64'h0, 4'd9, 64'h0, 1);
    chk("mis_ld_en", 64'(ram_en), 0);
    step();
    issue(64'h8000_0001, 1, 1, 0, 64'hFFFF, 4'd10, 64'h0, 1);
    chk("mis_st_en", 64'(ram_en), 0);
    chk("mis_st_wen", 64'(ram_wen), 0);
    step();
    issue(64'h8000_0000, 0, 3, 0, 64'h0, 4'd11, 64'h8001_0000_0000_0000, 0); step();
    idle();
    repeat (3) step();
`ifdef RAM_BRIDGE_PERF_EN
    chk("perf_rd", 64'(perf_rd_cnt), 6);
    chk("perf_wr", 64'(perf_wr_cnt), 3);
    chk("perf_stall", 64'(perf_stall_cnt), 0);
`endif

    // Backpressure: two responses fill the FIFO, the third request must wait.
    bus.resp_ready = 1'b0;
    issue(64'h8000_0000, 0, 3, 0, 64'h0, 4'd1, 64'h8001_0000_0000_0000, 0); step();
    issue(64'h8000_0006, 0, 1, 0, 64'h0, 4'd2, 64'h0000_0000_0000_8001, 0); step();
    bus.req_valid = 1'b1; bus.req_addr = 64'h8000_0004; bus.req_wen = 0;
    bus.req_size = 2; bus.req_signed = 0; bus.req_id = 4'd3;
    @(negedge clk);
    chk("full_req_ready", 64'(bus.req_ready), 0);
    chk("full_resp_valid", 64'(bus.resp_valid), 1);
    chk("full_head_id", 64'(bus.resp_id), 1);
    chk("full_ram_en", 64'(ram_en), 0);
    step();
    bus.resp_ready = 1'b1;
    issue(64'h8000_0004, 0, 2, 0, 64'h0, 4'd3, 64'h0000_0000_8001_0000, 0); step();
    issue(64'h8000_0000, 0, 3, 0, 64'h0, 4'd4, 64'h8001_0000_0000_0000, 0);
    chk("stream_ready", 64'(bus.req_ready), 1);
    chk("stream_head_id", 64'(bus.resp_id), 3);
    step();
    idle();
    repeat (3) step();

    // Reset with two responses buffered and a store presented.
    bus.resp_ready = 1'b0;
    issue(64'h8000_0000, 0, 3, 0, 64'h0, 4'd12, 64'h8001_0000_0000_0000, 0); step();
    issue(64'h8000_0000, 0, 3, 0, 64'h0, 4'd13, 64'h8001_0000_0000_0000, 0); step();
    bus.req_valid = 1'b1; bus.req_addr = 64'h8000_0000; bus.req_wen = 1'b1;
    bus.req_size = 3; bus.req_wdata = 64'hDEAD_BEEF_CAFE_F00D; bus.req_id = 4'd14;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ram_wen", 64'(ram_wen), 0);
    chk("rst_mid_ram_en", 64'(ram_en), 0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_mid_resp_valid", 64'(bus.resp_valid), 0);
    chk("rst_mid_req_ready", 64'(bus.req_ready), 1);
`ifdef RAM_BRIDGE_PERF_EN
    chk("rst_perf_rd", 64'(perf_rd_cnt), 0);
    chk("rst_perf_wr", 64'(perf_wr_cnt), 0);
    chk("rst_perf_stall", 64'(perf_stall_cnt), 0);
`endif
    step();
    bus.resp_ready = 1'b1;
    issue(64'h8000_0000, 0, 3, 0, 64'h0, 4'd15, 64'h8001_0000_0000_0000, 0); step();
    idle();

    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    chk("sb_drain", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
